// File: rtl/proj_pkg.sv
// Shared types and per-benchmark constants for the projection-cone stimulus sweeper.
package proj_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;

  // dk17 projection cone
  localparam int                DK17_N_IN   = 10;
  localparam int                DK17_SIG_W  = 16;
  localparam logic [15:0]       DK17_POLY   = 16'h1021;
  localparam logic [9:0]        DK17_LFSR_T = 10'h240;

endpackage

// File: rtl/proj_misr.sv
// Single-input MISR that folds the cone response stream into a signature.
module proj_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_reg;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = {sig_reg[SIG_W-2:0], 1'b0}
             ^ (sig_reg[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-1){1'b0}}, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else if (clr) begin
      sig_reg <= '0;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/proj_stim_sweep.sv
// Sweeps the cone input space (counter or Galois LFSR) over valid/ready and
// collects the onset count and MISR signature of the responses.
module proj_stim_sweep
  import proj_pkg::*;
#(
  parameter int               N_IN   = DK17_N_IN,
  parameter int               SIG_W  = DK17_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = DK17_POLY,
  parameter logic [N_IN-1:0]  LFSR_T = DK17_LFSR_T
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [N_IN-1:0]   seed,
  output logic [N_IN-1:0]   x_out,
  output logic              x_valid,
  input  logic              x_ready,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     vec_count,
  output logic [N_IN:0]     ones_count,
  output logic [SIG_W-1:0]  signature
);

  sweep_state_t      state_reg, state_next;
  logic [N_IN-1:0]   x_reg;
  logic [N_IN-1:0]   start_val_reg;
  logic              mode_reg;
  logic [N_IN:0]     vec_reg;
  logic [N_IN:0]     ones_reg;

  logic              running;
  logic              accept;
  logic              start_ok;
  logic              last_vec;
  logic [N_IN-1:0]   x_adv;
  logic [N_IN-1:0]   load_val;

  assign running  = (state_reg == RUN);
  assign accept   = running & x_ready;
  assign start_ok = start & ~running;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign load_val = mode ? ((seed == '0) ? N_IN'(1) : seed) : '0;

  always_comb begin
    if (mode_reg) begin
      x_adv = (x_reg >> 1) ^ (x_reg[0] ? LFSR_T : '0);
    end else begin
      x_adv = x_reg + N_IN'(1);
    end
  end

  assign last_vec = mode_reg ? (x_adv == start_val_reg) : (x_reg == '1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_vec) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      start_val_reg <= '0;
      mode_reg      <= 1'b0;
      vec_reg       <= '0;
      ones_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        x_reg         <= load_val;
        start_val_reg <= load_val;
        mode_reg      <= mode;
        vec_reg       <= '0;
        ones_reg      <= '0;
      end else if (accept) begin
        x_reg    <= x_adv;
        vec_reg  <= vec_reg + (N_IN+1)'(1);
        ones_reg <= ones_reg + (N_IN+1)'(y_in);
      end
    end
  end

  proj_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (accept),
    .din   (y_in),
    .sig   (signature)
  );

  assign x_out      = x_reg;
  assign x_valid    = running;
  assign busy       = running;
  assign done       = (state_reg == DONE);
  assign vec_count  = vec_reg;
  assign ones_count = ones_reg;

endmodule

// File: tb/tb_proj_stim_sweep.sv
// Directed bench for proj_stim_sweep: exhaustive and LFSR sweeps, backpressure,
// mid-sweep reset and ignored start pulses.
module tb_proj_stim_sweep;

  localparam int N_IN  = 10;
  localparam int SIG_W = 16;
  localparam int BUDGET = 8000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [N_IN-1:0]   seed = '0;
  logic [N_IN-1:0]   x_out;
  logic              x_valid;
  logic              x_ready = 1'b1;
  logic              y_in;
  logic              busy;
  logic              done;
  logic [N_IN:0]     vec_count;
  logic [N_IN:0]     ones_count;
  logic [SIG_W-1:0]  signature;
  bit                y_sel = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [SIG_W-1:0] sig_alt;

  always #5 clk = ~clk;

  // Cone stand-in: y0 = x0 when enabled, else constant 0.
  assign y_in = y_sel & x_out[0];

  proj_stim_sweep dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count),
    .ones_count (ones_count),
    .signature  (signature)
  );

  task automatic pulse_start(input bit m, input logic [N_IN-1:0] s);
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wait_done timeout: done=%b after %0d cycles, required 1", done, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({x_out, x_valid, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: x_out=%h x_valid=%b busy=%b done=%b, required all 0", x_out, x_valid, busy, done);
    end
    checks++;
    if (vec_count !== '0 || ones_count !== '0) begin
      failures++;
      $display("FAIL reset_counts: vec=%0d ones=%0d, required 0", vec_count, ones_count);
    end
    checks++;
    if (signature !== '0) begin
      failures++;
      $display("FAIL reset_sig: sig=%h, required 0000", signature);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_exhaustive_zero();
    int cycles;
    y_sel = 1'b0;
    x_ready = 1'b1;
    pulse_start(1'b0, '0);
    checks++;
    if (x_valid !== 1'b1 || x_out !== 10'h000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t1_first: x_valid=%b x_out=%h busy=%b, required 1 000 1", x_valid, x_out, busy);
    end
    wait_done(cycles);
    checks++;
    if (cycles !== 1025) begin
      failures++;
      $display("FAIL t1_latency: %0d cycles, required 1025", cycles);
    end
    checks++;
    if (vec_count !== 11'd1024 || ones_count !== 11'd0) begin
      failures++;
      $display("FAIL t1_counts: vec=%0d ones=%0d, required 1024 0", vec_count, ones_count);
    end
    checks++;
    if (signature !== 16'h0000 || x_valid !== 1'b0 || x_out !== 10'h000) begin
      failures++;
      $display("FAIL t1_final: sig=%h x_valid=%b x_out=%h, required 0000 0 000", signature, x_valid, x_out);
    end
    $display("test_exhaustive_zero: cycles=%0d vec=%0d ones=%0d sig=%h", cycles, vec_count, ones_count, signature);
  endtask

  task automatic test_exhaustive_alt();
    int cycles;
    y_sel = 1'b1;
    x_ready = 1'b1;
    pulse_start(1'b0, '0);
    wait_done(cycles);
    checks++;
    if (ones_count !== 11'd512 || vec_count !== 11'd1024) begin
      failures++;
      $display("FAIL t2_counts: ones=%0d vec=%0d, required 512 1024", ones_count, vec_count);
    end
    checks++;
    if (signature !== sig_alt) begin
      failures++;
      $display("FAIL t2_sig: sig=%h, required %h", signature, sig_alt);
    end
    $display("test_exhaustive_alt: ones=%0d sig=%h model=%h", ones_count, signature, sig_alt);
  endtask

  task automatic test_lfsr();
    int cycles;
    int repeats;
    int zeros;
    logic [N_IN-1:0] first_vec;
    bit seen [1024];
    bit got_first;
    foreach (seen[i]) seen[i] = 1'b0;
    repeats = 0;
    zeros = 0;
    got_first = 1'b0;
    first_vec = '0;
    y_sel = 1'b0;
    x_ready = 1'b1;
    pulse_start(1'b1, '0);
    cycles = 1;
    while (!done && cycles < BUDGET) begin
      if (x_valid && x_ready) begin
        if (!got_first) begin
          first_vec = x_out;
          got_first = 1'b1;
        end
        if (x_out == '0) zeros++;
        if (seen[x_out]) repeats++;
        seen[x_out] = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL t3_done: done=%b after %0d cycles, required 1", done, cycles);
    end
    checks++;
    if (first_vec !== 10'h001) begin
      failures++;
      $display("FAIL t3_first: first=%h, required 001", first_vec);
    end
    checks++;
    if (repeats !== 0 || zeros !== 0) begin
      failures++;
      $display("FAIL t3_unique: repeats=%0d zeros=%0d, required 0 0", repeats, zeros);
    end
    checks++;
    if (vec_count !== 11'd1023) begin
      failures++;
      $display("FAIL t3_vec: vec=%0d, required 1023", vec_count);
    end
    checks++;
    if (x_out !== 10'h001) begin
      failures++;
      $display("FAIL t3_final_x: x_out=%h, required 001", x_out);
    end
    $display("test_lfsr: vec=%0d repeats=%0d final_x=%h", vec_count, repeats, x_out);
  endtask

  task automatic test_backpressure();
    int cycles;
    int viol;
    int stalls;
    logic [N_IN-1:0] prev_x;
    bit prev_valid;
    bit prev_ready;
    viol = 0;
    stalls = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_x = '0;
    y_sel = 1'b1;
    x_ready = 1'b0;
    pulse_start(1'b0, '0);
    cycles = 1;
    while (!done && cycles < 3 * BUDGET) begin
      if (prev_valid && !prev_ready) begin
        stalls++;
        if (x_out !== prev_x || x_valid !== 1'b1) viol++;
      end
      prev_x = x_out;
      prev_valid = x_valid;
      x_ready = ($urandom_range(0, 9) < 3);
      prev_ready = x_ready;
      @(negedge clk);
      cycles++;
    end
    x_ready = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL t4_done: done=%b after %0d cycles, required 1", done, cycles);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL t4_stable: %0d unstable stall cycles of %0d, required 0", viol, stalls);
    end
    checks++;
    if (vec_count !== 11'd1024 || ones_count !== 11'd512) begin
      failures++;
      $display("FAIL t4_counts: vec=%0d ones=%0d, required 1024 512", vec_count, ones_count);
    end
    checks++;
    if (signature !== sig_alt) begin
      failures++;
      $display("FAIL t4_sig: sig=%h, required %h", signature, sig_alt);
    end
    $display("test_backpressure: cycles=%0d stalls=%0d vec=%0d sig=%h", cycles, stalls, vec_count, signature);
  endtask

  task automatic test_mid_reset();
    int cycles;
    y_sel = 1'b1;
    x_ready = 1'b1;
    pulse_start(1'b0, '0);
    cycles = 0;
    while (vec_count != 11'd300 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (vec_count !== 11'd300) begin
      failures++;
      $display("FAIL t5_reach: vec=%0d, required 300", vec_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x_out, x_valid, busy, done} !== '0 || vec_count !== '0 || ones_count !== '0 || signature !== '0) begin
      failures++;
      $display("FAIL t5_reset: x=%h v=%b b=%b d=%b vec=%0d ones=%0d sig=%h, required all 0",
               x_out, x_valid, busy, done, vec_count, ones_count, signature);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1'b0, '0);
    checks++;
    if (vec_count !== 11'd0 || x_out !== 10'h000) begin
      failures++;
      $display("FAIL t5_fresh: vec=%0d x_out=%h, required 0 000", vec_count, x_out);
    end
    wait_done(cycles);
    checks++;
    if (vec_count !== 11'd1024 || ones_count !== 11'd512) begin
      failures++;
      $display("FAIL t5_counts: vec=%0d ones=%0d, required 1024 512", vec_count, ones_count);
    end
    $display("test_mid_reset: vec=%0d ones=%0d", vec_count, ones_count);
  endtask

  task automatic test_start_ignored();
    int cycles;
    y_sel = 1'b0;
    x_ready = 1'b1;
    pulse_start(1'b0, '0);
    cycles = 0;
    while (vec_count != 11'd100 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (vec_count !== 11'd101 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t6_run_start: vec=%0d busy=%b, required 101 1", vec_count, busy);
    end
    cycles = 0;
    while (!(x_valid && x_out == 10'h3FF) && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || vec_count !== 11'd1024) begin
      failures++;
      $display("FAIL t6_final: done=%b vec=%0d, required 1 1024", done, vec_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || vec_count !== 11'd1024) begin
      failures++;
      $display("FAIL t6_hold: done=%b busy=%b vec=%0d, required 1 0 1024", done, busy, vec_count);
    end
    $display("test_start_ignored: done=%b vec=%0d", done, vec_count);
  endtask

  initial begin
    logic [SIG_W-1:0] s;
    s = '0;
    for (int i = 0; i < 1024; i++) begin
      s = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? 16'h1021 : 16'h0000) ^ {15'd0, i[0]};
    end
    sig_alt = s;

    test_reset();
    test_exhaustive_zero();
    test_exhaustive_alt();
    test_lfsr();
    test_backpressure();
    test_mid_reset();
    test_start_ignored();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
